// File: rtl/vga_rgb332_dither_encoder.sv
// 24-bit BGR to RGB332 quantizer with a 4x4 ordered dither and a two-stage
// valid/ready pipeline that stalls as a whole when the output is blocked.
module vga_rgb332_dither_encoder (
    input  logic        clock,
    input  logic        reset,
    input  logic [23:0] bgr_data,
    input  logic        in_valid,
    input  logic        in_sof,
    input  logic        in_eol,
    input  logic        dither_en,
    output logic        in_ready,
    output logic [7:0]  pixel,
    output logic        out_valid,
    input  logic        out_ready
);

    logic       advance;
    logic       accept;
    logic [1:0] x_reg;
    logic [1:0] y_reg;
    logic [1:0] use_x;
    logic [1:0] use_y;
    logic [3:0] bayer_d;
    logic [7:0] sum_next [3];
    logic [7:0] sum_reg  [3];
    logic       s1_valid_reg;
    logic [7:0] pixel_reg;
    logic       out_valid_reg;

    assign advance   = !out_valid_reg || out_ready;
    assign accept    = in_valid && advance;
    assign in_ready  = advance;
    assign pixel     = pixel_reg;
    assign out_valid = out_valid_reg;

    // A start-of-frame pixel always sits at the top-left of the dither tile.
    assign use_x = in_sof ? 2'd0 : x_reg;
    assign use_y = in_sof ? 2'd0 : y_reg;

    always_comb begin
        bayer_d = 4'd0;
        case ({use_y, use_x})
            4'h0: bayer_d = 4'd0;   4'h1: bayer_d = 4'd8;
            4'h2: bayer_d = 4'd2;   4'h3: bayer_d = 4'd10;
            4'h4: bayer_d = 4'd12;  4'h5: bayer_d = 4'd4;
            4'h6: bayer_d = 4'd14;  4'h7: bayer_d = 4'd6;
            4'h8: bayer_d = 4'd3;   4'h9: bayer_d = 4'd11;
            4'hA: bayer_d = 4'd1;   4'hB: bayer_d = 4'd9;
            4'hC: bayer_d = 4'd15;  4'hD: bayer_d = 4'd7;
            4'hE: bayer_d = 4'd13;  4'hF: bayer_d = 4'd5;
            default: bayer_d = 4'd0;
        endcase
    end

    // Channel 0 = R, 1 = G, 2 = B; blue keeps only two bits so it gets twice the offset.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            logic [7:0] chan_val;
            logic [8:0] chan_off;
            logic [8:0] chan_sum;
            assign chan_val = bgr_data[gi*8 +: 8];
            assign chan_off = !dither_en ? 9'd0 :
                              (gi == 2)  ? {3'b000, bayer_d, 2'b00} :
                                           {4'b0000, bayer_d, 1'b0};
            assign chan_sum = {1'b0, chan_val} + chan_off;
            assign sum_next[gi] = chan_sum[8] ? 8'hFF : chan_sum[7:0];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            x_reg         <= 2'd0;
            y_reg         <= 2'd0;
            s1_valid_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            pixel_reg     <= 8'h00;
            for (int i = 0; i < 3; i++) sum_reg[i] <= 8'h00;
        end else if (advance) begin
            s1_valid_reg  <= in_valid;
            out_valid_reg <= s1_valid_reg;
            if (in_valid) begin
                for (int i = 0; i < 3; i++) sum_reg[i] <= sum_next[i];
                if (in_eol) begin
                    x_reg <= 2'd0;
                    y_reg <= use_y + 2'd1;
                end else begin
                    x_reg <= use_x + 2'd1;
                    y_reg <= use_y;
                end
            end
            if (s1_valid_reg)
                pixel_reg <= {sum_reg[0][7:5], sum_reg[1][7:5], sum_reg[2][7:6]};
        end
    end

endmodule
